// File: rtl/bus_arbiter.sv
// Two-into-one bus arbiter: shares the AXI read/write bridge between instruction fetch and load/store.
// Tie-break is fixed (MEM wins) unless BUS_ARB_RR_EN is defined, which selects round-robin.
module bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_valid,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic [1:0]        if_size,
    input  logic              if_req,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_data_read,
    output logic [1:0]        if_resp,

    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [1:0]        mem_size,
    input  logic              mem_req,
    input  logic [DATA_W-1:0] mem_data_write,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_data_read,
    output logic [1:0]        mem_resp,

    output logic              rw_valid_o,
    input  logic              rw_ready_i,
    output logic              rw_req_o,
    output logic [ADDR_W-1:0] rw_addr_o,
    output logic [1:0]        rw_size_o,
    output logic [DATA_W-1:0] rw_w_data_o,
    input  logic [DATA_W-1:0] rw_r_data_i,
    input  logic [1:0]        rw_resp_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              pick_mem;
    logic              if_done;
    logic              mem_done;

`ifdef BUS_ARB_RR_EN
    // 1 = MEM held the last grant; on a tie the other requester wins.
    logic last_gnt_q, last_gnt_d;

    assign pick_mem = mem_valid && (!if_valid || !last_gnt_q);
`else
    assign pick_mem = mem_valid;
`endif

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        req_d   = req_q;
        wdata_d = wdata_q;
`ifdef BUS_ARB_RR_EN
        last_gnt_d = last_gnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_mem) begin
                    state_d = GNT_MEM;
                    addr_d  = mem_addr;
                    size_d  = mem_size;
                    req_d   = mem_req;
                    wdata_d = mem_data_write;
`ifdef BUS_ARB_RR_EN
                    last_gnt_d = 1'b1;
`endif
                end else if (if_valid) begin
                    state_d = GNT_IF;
                    addr_d  = if_addr;
                    size_d  = if_size;
                    req_d   = if_req;
                    wdata_d = '0;
`ifdef BUS_ARB_RR_EN
                    last_gnt_d = 1'b0;
`endif
                end
            end
            // Request fields stay frozen until the bridge completes; a dropped valid does not abort.
            GNT_IF, GNT_MEM: begin
                if (rw_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            req_q   <= 1'b0;
            wdata_q <= '0;
`ifdef BUS_ARB_RR_EN
            last_gnt_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            req_q   <= req_d;
            wdata_q <= wdata_d;
`ifdef BUS_ARB_RR_EN
            last_gnt_q <= last_gnt_d;
`endif
        end
    end

    assign rw_valid_o  = (state_q != IDLE);
    assign rw_req_o    = req_q;
    assign rw_addr_o   = addr_q;
    assign rw_size_o   = size_q;
    assign rw_w_data_o = wdata_q;

    // Completion is routed only to the granted requester, and only in the bridge's ready cycle.
    assign if_done  = (state_q == GNT_IF)  && rw_ready_i;
    assign mem_done = (state_q == GNT_MEM) && rw_ready_i;

    assign if_ready      = if_done;
    assign if_data_read  = if_done ? rw_r_data_i : '0;
    assign if_resp       = if_done ? rw_resp_i : 2'b00;
    assign mem_ready     = mem_done;
    assign mem_data_read = mem_done ? rw_r_data_i : '0;
    assign mem_resp      = mem_done ? rw_resp_i : 2'b00;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized and directed bench for bus_arbiter with a queue scoreboard and a transaction-level model.
// Tie-break expectations follow BUS_ARB_RR_EN when it is defined.
module tb_bus_arbiter;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int IFR  = 1;
    localparam int MEMR = 2;
`ifdef BUS_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              if_valid, if_req, if_ready;
    logic [ADDR_W-1:0] if_addr;
    logic [1:0]        if_size, if_resp;
    logic [DATA_W-1:0] if_data_read;
    logic              mem_valid, mem_req, mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_size, mem_resp;
    logic [DATA_W-1:0] mem_data_write, mem_data_read;
    logic              rw_valid_o, rw_ready_i, rw_req_o;
    logic [ADDR_W-1:0] rw_addr_o;
    logic [1:0]        rw_size_o, rw_resp_i;
    logic [DATA_W-1:0] rw_w_data_o, rw_r_data_i;

    bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_req(if_req),
        .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_size(mem_size), .mem_req(mem_req),
        .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_data_read(mem_data_read),
        .mem_resp(mem_resp),
        .rw_valid_o(rw_valid_o), .rw_ready_i(rw_ready_i), .rw_req_o(rw_req_o),
        .rw_addr_o(rw_addr_o), .rw_size_o(rw_size_o), .rw_w_data_o(rw_w_data_o),
        .rw_r_data_i(rw_r_data_i), .rw_resp_i(rw_resp_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
    } rsp_t;
    rsp_t rsp_q[$];
    int   done_log[$];
    int   if_pulses = 0, mem_pulses = 0;
    logic [DATA_W-1:0] last_if_data = '0;
    logic [1:0]        last_if_resp = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bridge stimulus: any accepted completion is queued as the expected response.
    task automatic drive_bridge(input logic rdy, input logic [DATA_W-1:0] d, input logic [1:0] r);
        rsp_t e;
        rw_ready_i  = rdy;
        rw_r_data_i = d;
        rw_resp_i   = r;
        if (rdy && rw_valid_o) begin
            e.data = d;
            e.resp = r;
            rsp_q.push_back(e);
        end
    endtask

    // Transaction-level reference: who owns the bus and which request fields were captured.
    int                m_busy = 0;
    int                m_last = MEMR;
    logic [ADDR_W-1:0] m_addr;
    logic [1:0]        m_size;
    logic              m_req;
    logic [DATA_W-1:0] m_wdata;
    logic              p_rst = 1'b1, p_if_v = 1'b0, p_mem_v = 1'b0, p_rdy = 1'b0;
    logic [ADDR_W-1:0] p_if_addr, p_mem_addr;
    logic [1:0]        p_if_size, p_mem_size;
    logic              p_if_req, p_mem_req;
    logic [DATA_W-1:0] p_mem_wdata;

    initial forever begin : monitor
        int   w;
        rsp_t r;
        logic exp_done;
        @(negedge clk);
        #2;
        if (p_rst) begin
            m_busy = 0; m_last = MEMR;
            m_addr = '0; m_size = '0; m_req = 1'b0; m_wdata = '0;
        end else if (m_busy != 0) begin
            if (p_rdy) m_busy = 0;
        end else if (p_if_v || p_mem_v) begin
            if (p_if_v && p_mem_v) w = RR ? ((m_last == MEMR) ? IFR : MEMR) : MEMR;
            else                   w = p_mem_v ? MEMR : IFR;
            m_busy = w;
            m_last = w;
            if (w == MEMR) begin
                m_addr = p_mem_addr; m_size = p_mem_size; m_req = p_mem_req; m_wdata = p_mem_wdata;
            end else begin
                m_addr = p_if_addr;  m_size = p_if_size;  m_req = p_if_req;  m_wdata = '0;
            end
        end
        chk("rw_valid_o", rw_valid_o, m_busy != 0);
        if (m_busy != 0 || p_rst) begin
            chk("rw_addr_o", rw_addr_o, m_addr);
            chk("rw_size_o", rw_size_o, m_size);
            chk("rw_req_o", rw_req_o, m_req);
            chk("rw_w_data_o", rw_w_data_o, m_wdata);
        end
        exp_done = (m_busy != 0) && rw_ready_i;
        if (exp_done) begin
            if (rsp_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL rsp_queue: got empty queue expected a pending response");
            end else begin
                r = rsp_q.pop_front();
                chk("if_ready", if_ready, m_busy == IFR);
                chk("mem_ready", mem_ready, m_busy == MEMR);
                chk("if_data_read", if_data_read, (m_busy == IFR) ? r.data : '0);
                chk("if_resp", if_resp, (m_busy == IFR) ? r.resp : 2'b00);
                chk("mem_data_read", mem_data_read, (m_busy == MEMR) ? r.data : '0);
                chk("mem_resp", mem_resp, (m_busy == MEMR) ? r.resp : 2'b00);
            end
        end else begin
            chk("if_ready_idle", if_ready, 1'b0);
            chk("mem_ready_idle", mem_ready, 1'b0);
            chk("if_data_idle", if_data_read, '0);
            chk("if_resp_idle", if_resp, 2'b00);
            chk("mem_data_idle", mem_data_read, '0);
            chk("mem_resp_idle", mem_resp, 2'b00);
        end
        if (if_ready) begin
            done_log.push_back(IFR);
            if_pulses++;
            last_if_data = if_data_read;
            last_if_resp = if_resp;
        end
        if (mem_ready) begin
            done_log.push_back(MEMR);
            mem_pulses++;
        end
        #2;
        p_rst = rst; p_rdy = rw_ready_i;
        p_if_v = if_valid; p_if_addr = if_addr; p_if_size = if_size; p_if_req = if_req;
        p_mem_v = mem_valid; p_mem_addr = mem_addr; p_mem_size = mem_size; p_mem_req = mem_req;
        p_mem_wdata = mem_data_write;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int gc;
        int seq_exp[7];
        int if_gap, mem_gap, bcnt;
        logic if_busy, mem_busy, if_done, mem_done;

        rst = 1'b1;
        if_valid = 0; if_addr = '0; if_size = '0; if_req = 0;
        mem_valid = 0; mem_addr = '0; mem_size = '0; mem_req = 0; mem_data_write = '0;
        rw_ready_i = 0; rw_r_data_i = '0; rw_resp_i = '0;
        repeat (3) @(negedge clk);

        // Tie straight out of reset, then continuous contention with a 1-cycle bridge.
        rst = 1'b0;
        if_valid = 1; if_addr = 64'h8000_0000; if_size = 2; if_req = 0;
        mem_valid = 1; mem_addr = 64'h8000_1000; mem_size = 3; mem_req = 1;
        mem_data_write = 64'hDEAD_BEEF;
        done_log.delete();
        gc = 0;
        while (done_log.size() < 7 && gc < 60) begin
            @(negedge clk);
            gc++;
            if (done_log.size() >= 6) mem_valid = 0;
            drive_bridge(rw_valid_o, DATA_W'($urandom), 2'b00);
            #3;
        end
        if_valid = 0; mem_valid = 0;
        @(negedge clk);
        drive_bridge(0, '0, 2'b00);
        for (int i = 0; i < 7; i++) seq_exp[i] = RR ? ((i % 2 == 0) ? IFR : MEMR) : ((i < 6) ? MEMR : IFR);
        chk("contention_count", done_log.size(), 7);
        for (int i = 0; i < 7 && i < done_log.size(); i++) chk($sformatf("grant_seq[%0d]", i), done_log[i], seq_exp[i]);
        repeat (2) @(negedge clk);

        // Lone fetch, bridge ready 3 cycles after the grant.
        if_pulses = 0; mem_pulses = 0; gc = 0;
        if_valid = 1; if_addr = 64'h8000_0000; if_size = 2; if_req = 0;
        for (int c = 0; c < 20 && if_pulses == 0; c++) begin
            @(negedge clk);
            if (rw_valid_o) begin
                if (gc == 0) chk("fetch_addr", rw_addr_o, 64'h8000_0000);
                gc++;
                drive_bridge(gc == 4, 64'h13, 2'b00);
            end else drive_bridge(0, 64'h55, 2'b00);
            #3;
        end
        if_valid = 0;
        repeat (3) begin @(negedge clk); drive_bridge(0, '0, 2'b00); end
        chk("fetch_pulses", if_pulses, 1);
        chk("fetch_mem_quiet", mem_pulses, 0);
        chk("fetch_data", last_if_data, 64'h13);
        chk("fetch_latency", gc, 4);

        // Store fields stay latched while the requester changes its inputs.
        mem_pulses = 0; gc = 0;
        mem_valid = 1; mem_req = 1; mem_addr = 64'h8000_1000; mem_size = 3; mem_data_write = 64'hDEAD_BEEF;
        for (int c = 0; c < 20 && mem_pulses == 0; c++) begin
            @(negedge clk);
            if (rw_valid_o) begin
                gc++;
                mem_data_write = {$urandom, $urandom};
                mem_addr = {$urandom, $urandom};
                drive_bridge(gc == 4, '0, 2'b00);
                #1;
                chk("store_wdata", rw_w_data_o, 64'hDEAD_BEEF);
                chk("store_req", rw_req_o, 1'b1);
                #2;
            end else begin
                drive_bridge(0, '0, 2'b00);
                #3;
            end
        end
        mem_valid = 0;
        @(negedge clk); drive_bridge(0, '0, 2'b00);
        chk("store_pulses", mem_pulses, 1);

        // Error response passes through once, with no retry.
        if_pulses = 0;
        if_valid = 1; if_addr = 64'h8000_0040; if_size = 2; if_req = 0;
        for (int c = 0; c < 10 && if_pulses == 0; c++) begin
            @(negedge clk);
            drive_bridge(rw_valid_o, 64'h0, 2'b10);
            #3;
        end
        if_valid = 0;
        chk("err_resp", last_if_resp, 2'b10);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_bridge(0, '0, 2'b00);
            #1;
            chk("err_no_retry", rw_valid_o, 1'b0);
        end
        chk("err_pulses", if_pulses, 1);

        // Reset in the middle of a MEM grant; a late bridge ready must not leak through.
        mem_pulses = 0; gc = 0;
        mem_valid = 1; mem_req = 0; mem_addr = 64'h8000_2001; mem_size = 1;
        for (int c = 0; c < 10 && gc < 2; c++) begin
            @(negedge clk);
            drive_bridge(0, '0, 2'b00);
            if (rw_valid_o) gc++;
        end
        chk("rst_pre_grant", rw_valid_o, 1'b1);
        rst = 1; mem_valid = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("rst_valid", rw_valid_o, 1'b0);
        chk("rst_addr", rw_addr_o, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            drive_bridge(1, 64'hBAD, 2'b11);
            #1;
            chk("rst_no_fwd_ready", mem_ready, 1'b0);
            chk("rst_no_fwd_data", mem_data_read, '0);
        end
        @(negedge clk); drive_bridge(0, '0, 2'b00);
        chk("rst_pulses", mem_pulses, 0);

        // Random traffic; requesters may drop valid or scramble fields once granted.
        if_busy = 0; mem_busy = 0; if_done = 0; mem_done = 0;
        if_gap = 0; mem_gap = 1; bcnt = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (if_busy && if_done) begin if_busy = 0; if_gap = $urandom_range(0, 3); end
            if (!if_busy) begin
                if (if_gap == 0) begin
                    if_busy = 1; if_valid = 1;
                    if_addr = {$urandom, $urandom} & ~64'h1;
                    if_size = 2'($urandom); if_req = 1'($urandom);
                end else begin
                    if_gap--; if_valid = 0;
                end
            end else if (rw_valid_o && !rw_addr_o[0]) begin
                if ($urandom_range(0, 3) == 0) if_valid = 0;
                if_addr = {$urandom, $urandom} & ~64'h1;
            end
            if (mem_busy && mem_done) begin mem_busy = 0; mem_gap = $urandom_range(0, 3); end
            if (!mem_busy) begin
                if (mem_gap == 0) begin
                    mem_busy = 1; mem_valid = 1;
                    mem_addr = {$urandom, $urandom} | 64'h1;
                    mem_size = 2'($urandom); mem_req = 1'($urandom);
                    mem_data_write = {$urandom, $urandom};
                end else begin
                    mem_gap--; mem_valid = 0;
                end
            end else if (rw_valid_o && rw_addr_o[0]) begin
                if ($urandom_range(0, 3) == 0) mem_valid = 0;
                mem_data_write = {$urandom, $urandom};
            end
            if (rw_valid_o) begin
                if (bcnt == 0) begin
                    drive_bridge(1, {$urandom, $urandom}, 2'($urandom));
                    bcnt = $urandom_range(0, 3);
                end else begin
                    bcnt--;
                    drive_bridge(0, {$urandom, $urandom}, 2'($urandom));
                end
            end else drive_bridge($urandom_range(0, 3) == 0, {$urandom, $urandom}, 2'($urandom));
            #1;
            if_done = if_ready;
            mem_done = mem_ready;
        end
        if_valid = 0; mem_valid = 0;
        repeat (12) begin
            @(negedge clk);
            drive_bridge(rw_valid_o, {$urandom, $urandom}, 2'b00);
        end
        @(negedge clk); drive_bridge(0, '0, 2'b00);
        #3;
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("final_idle", rw_valid_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
